comp_sequencer: RTL and testbench

//  Sequencer for the registered 10-bit comparator (clk, c, d -> comp). Owns the

---
 rtl/comp_seq_pkg.sv | 17 +
 rtl/wrap_counter.sv | 27 ++
 rtl/comp_sequencer.sv | 114 +++++++++++
 tb/tb_comp_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_seq_pkg.sv
// Shared defaults and FSM state encoding for the comparator sequencer.
package comp_seq_pkg;

  localparam int unsigned DEF_W       = 10;
  localparam int unsigned DEF_N_THR   = 4;
  localparam int unsigned DEF_CNT_MAX = 799;
  localparam int unsigned IDX_W       = $clog2(DEF_N_THR);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StSettle,
    StWait,
    StAdv
  } seq_state_e;

endpackage

// File: rtl/wrap_counter.sv
// Free-running modulo-(CNT_MAX+1) counter; wrap is high in the cycle that
// holds CNT_MAX, i.e. the next edge takes the count back to 0.
module wrap_counter #(
  parameter int unsigned W       = 10,
  parameter int unsigned CNT_MAX = 799
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MaxVal = W'(CNT_MAX);

  assign wrap = (count == MaxVal);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/comp_sequencer.sv
// Drives the comparator's c (free-running count) and d (threshold table entry),
// reporting a hit or miss per entry and done after the last one.
module comp_sequencer
  import comp_seq_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned N_THR   = DEF_N_THR,
  parameter int unsigned CNT_MAX = DEF_CNT_MAX,
  localparam int unsigned IdxW   = $clog2(N_THR),
  localparam int unsigned NumW   = IdxW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            thr_we,
  input  logic [IdxW-1:0] thr_addr,
  input  logic [W-1:0]    thr_data,
  input  logic [NumW-1:0] num_thr,
  input  logic            start,
  output logic [W-1:0]    c_out,
  output logic [W-1:0]    d_out,
  input  logic            comp_in,
  output logic            busy,
  output logic            hit,
  output logic [IdxW-1:0] hit_idx,
  output logic            miss,
  output logic            done
);

  localparam logic [NumW-1:0] NumMax = NumW'(N_THR);

  seq_state_e      state_q;
  logic [W-1:0]    table_q [N_THR];
  logic [IdxW-1:0] idx_q;
  logic [NumW-1:0] num_q;
  logic [1:0]      wraps_q;
  logic            cnt_wrap;

  wrap_counter #(
    .W       (W),
    .CNT_MAX (CNT_MAX)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .count (c_out),
    .wrap  (cnt_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      num_q   <= '0;
      wraps_q <= '0;
      d_out   <= '0;
      busy    <= 1'b0;
      hit     <= 1'b0;
      miss    <= 1'b0;
      done    <= 1'b0;
      hit_idx <= '0;
      for (int i = 0; i < N_THR; i++) table_q[i] <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      done <= 1'b0;
      // Writes land before ARM reads, so a same-cycle write+start is seen.
      if (thr_we && !busy) table_q[thr_addr] <= thr_data;

      case (state_q)
        StIdle: begin
          if (start && (num_thr != '0) && (num_thr <= NumMax)) begin
            num_q   <= num_thr;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StArm;
          end
        end
        StArm: begin
          d_out   <= table_q[idx_q];
          wraps_q <= '0;
          state_q <= StSettle;
        end
        // comp_in still reflects the previous d this cycle.
        StSettle: state_q <= StWait;
        StWait: begin
          if (comp_in) begin
            hit     <= 1'b1;
            hit_idx <= idx_q;
            state_q <= StAdv;
          end else if (cnt_wrap) begin
            if (wraps_q == 2'd1) begin
              miss    <= 1'b1;
              hit_idx <= idx_q;
              state_q <= StAdv;
            end else begin
              wraps_q <= wraps_q + 2'd1;
            end
          end
        end
        StAdv: begin
          if ({1'b0, idx_q} == num_q - 1'b1) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StArm;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_sequencer.sv
// Directed bench for comp_sequencer with a behavioural registered comparator.
module tb_comp_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       thr_we = 1'b0;
  logic [1:0] thr_addr = '0;
  logic [9:0] thr_data = '0;
  logic [2:0] num_thr = '0;
  logic       start = 1'b0;
  logic [9:0] c_out, d_out;
  logic       comp = 1'b0;
  logic       busy, hit, miss, done;
  logic [1:0] hit_idx;

  int vectors = 0;
  int miscompares = 0;

  // Run record
  int ev_kind [8];  // 1 = hit, 2 = miss
  int ev_idx [8];
  int ev_c [8];
  int ev_cyc [8];
  int n_ev, done_cyc, done_c;
  bit timed_out, overlap, busy21;

  comp_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .thr_we   (thr_we),
    .thr_addr (thr_addr),
    .thr_data (thr_data),
    .num_thr  (num_thr),
    .start    (start),
    .c_out    (c_out),
    .d_out    (d_out),
    .comp_in  (comp),
    .busy     (busy),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .miss     (miss),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Registered comparator: high the cycle after c == d.
  always @(posedge clk) comp <= (c_out == d_out);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [9:0] v);
    thr_we = 1'b1; thr_addr = a; thr_data = v;
    tick();
    thr_we = 1'b0;
  endtask

  // Starts a sequence while c_out = 50 and logs events; k = 1 is the cycle
  // showing c_out = 51.
  task automatic run_seq(input logic [2:0] n, input bit inj_wr, input bit inj_start);
    int w = 0;
    int k = 1;
    n_ev = 0; done_cyc = -1; done_c = -1; timed_out = 0; overlap = 0; busy21 = 0;
    while (c_out !== 10'd50 && w < 1000) begin tick(); w++; end
    if (w >= 1000) timed_out = 1;
    start = 1'b1; num_thr = n;
    tick();
    start = 1'b0;
    while (k <= 2000) begin
      if (hit === 1'b1 || miss === 1'b1) begin
        if (hit === 1'b1 && miss === 1'b1) overlap = 1;
        if (n_ev < 8) begin
          ev_kind[n_ev] = hit ? 1 : 2; ev_idx[n_ev] = int'(hit_idx);
          ev_c[n_ev] = int'(c_out); ev_cyc[n_ev] = k;
        end
        n_ev++;
      end
      if (done === 1'b1) begin
        if (hit === 1'b1 || miss === 1'b1) overlap = 1;
        done_cyc = k; done_c = int'(c_out);
        break;
      end
      if (inj_wr && k == 10) begin thr_we = 1'b1; thr_addr = 2'd0; thr_data = 10'd300; end
      if (k == 11) thr_we = 1'b0;
      if (inj_start && k == 20) begin start = 1'b1; num_thr = 3'd2; end
      if (inj_start && k == 21) begin start = 1'b0; busy21 = busy; end
      tick();
      k++;
    end
    if (done_cyc < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({c_out, d_out, busy, hit, miss, done, hit_idx} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got c=%0d d=%0d b=%0b h=%0b m=%0b dn=%0b idx=%0d expected all 0",
               c_out, d_out, busy, hit, miss, done, hit_idx);
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (c_out !== 10'(i)) begin
        miscompares++;
        $display("FAIL reset_count got %0d expected %0d", c_out, i);
      end
    end
  endtask

  task automatic test_two_hits();
    load(2'd0, 10'd100);
    load(2'd1, 10'd725);
    run_seq(3'd2, 0, 0);
    vectors++;
    if (timed_out || overlap || n_ev != 2) begin
      miscompares++;
      $display("FAIL two_hits_shape got to=%0b ov=%0b n=%0d expected 0 0 2", timed_out, overlap, n_ev);
    end
    vectors++;
    if (ev_kind[0] != 1 || ev_idx[0] != 0 || ev_c[0] != 102) begin
      miscompares++;
      $display("FAIL hit0 got kind=%0d idx=%0d c=%0d expected 1 0 102", ev_kind[0], ev_idx[0], ev_c[0]);
    end
    vectors++;
    if (ev_kind[1] != 1 || ev_idx[1] != 1 || ev_c[1] != 727) begin
      miscompares++;
      $display("FAIL hit1 got kind=%0d idx=%0d c=%0d expected 1 1 727", ev_kind[1], ev_idx[1], ev_c[1]);
    end
    vectors++;
    if (done_c != 728 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL two_hits_done got c=%0d busy=%0b expected 728 0", done_c, busy);
    end
    vectors++;
    if (d_out !== 10'd725) begin
      miscompares++;
      $display("FAIL d_hold got %0d expected 725", d_out);
    end
  endtask

  task automatic test_miss();
    load(2'd0, 10'd900);
    run_seq(3'd1, 0, 0);
    vectors++;
    if (timed_out || overlap || n_ev != 1 || ev_kind[0] != 2 || ev_idx[0] != 0) begin
      miscompares++;
      $display("FAIL miss_kind got to=%0b ov=%0b n=%0d kind=%0d idx=%0d expected 0 0 1 2 0",
               timed_out, overlap, n_ev, ev_kind[0], ev_idx[0]);
    end
    vectors++;
    if (ev_cyc[0] != 1550 || ev_c[0] != 0 || done_cyc != 1551) begin
      miscompares++;
      $display("FAIL miss_time got cyc=%0d c=%0d done=%0d expected 1550 0 1551",
               ev_cyc[0], ev_c[0], done_cyc);
    end
  endtask

  task automatic test_write_while_busy();
    load(2'd0, 10'd100);
    run_seq(3'd1, 1, 0);
    vectors++;
    if (timed_out || n_ev != 1 || ev_c[0] != 102 || d_out !== 10'd100) begin
      miscompares++;
      $display("FAIL busy_write_run1 got to=%0b n=%0d c=%0d d=%0d expected 0 1 102 100",
               timed_out, n_ev, ev_c[0], d_out);
    end
    run_seq(3'd1, 0, 0);
    vectors++;
    if (timed_out || n_ev != 1 || ev_kind[0] != 1 || ev_c[0] != 102) begin
      miscompares++;
      $display("FAIL busy_write_rerun got to=%0b n=%0d kind=%0d c=%0d expected 0 1 1 102",
               timed_out, n_ev, ev_kind[0], ev_c[0]);
    end
  endtask

  task automatic test_start_ignored();
    run_seq(3'd1, 0, 1);
    vectors++;
    if (timed_out || busy21 !== 1'b1 || n_ev != 1 || done_cyc != 53) begin
      miscompares++;
      $display("FAIL start_busy got to=%0b busy=%0b n=%0d done=%0d expected 0 1 1 53",
               timed_out, busy21, n_ev, done_cyc);
    end
    start = 1'b1; num_thr = 3'd0;
    tick();
    start = 1'b0;
    tick(); tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_num0 got busy=%0b expected 0", busy);
    end
    start = 1'b1; num_thr = 3'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_num5 got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    load(2'd0, 10'd200);
    load(2'd1, 10'd200);
    run_seq(3'd2, 0, 0);
    vectors++;
    if (timed_out || overlap || n_ev != 2 || ev_cyc[0] != 152 || ev_cyc[1] != 952) begin
      miscompares++;
      $display("FAIL stale_hits got to=%0b ov=%0b n=%0d cyc0=%0d cyc1=%0d expected 0 0 2 152 952",
               timed_out, overlap, n_ev, ev_cyc[0], ev_cyc[1]);
    end
    vectors++;
    if (ev_idx[1] != 1 || done_cyc != 953) begin
      miscompares++;
      $display("FAIL stale_done got idx1=%0d done=%0d expected 1 953", ev_idx[1], done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    load(2'd0, 10'd500);
    start = 1'b1; num_thr = 3'd1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    vectors++;
    if (busy !== 1'b1 || d_out !== 10'd500) begin
      miscompares++;
      $display("FAIL mid_pre got busy=%0b d=%0d expected 1 500", busy, d_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({busy, done, hit, miss} !== 4'b0 || d_out !== 10'd0 || c_out !== 10'd0) begin
      miscompares++;
      $display("FAIL mid_reset got busy=%0b done=%0b d=%0d c=%0d expected 0 0 0 0",
               busy, done, d_out, c_out);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL mid_no_done got %0d expected 0", dones);
    end
    run_seq(3'd1, 0, 0);
    vectors++;
    if (timed_out || n_ev != 1 || ev_kind[0] != 1 || ev_c[0] != 2) begin
      miscompares++;
      $display("FAIL mid_table_zero got to=%0b n=%0d kind=%0d c=%0d expected 0 1 1 2",
               timed_out, n_ev, ev_kind[0], ev_c[0]);
    end
  endtask

  initial begin
    test_reset();
    test_two_hits();
    test_miss();
    test_write_while_busy();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
